// File: rtl/execute_stage_fifo.sv
// Execute-to-memory pipeline stage: a DEPTH-entry circular buffer with valid/ready
// handshakes, flush, x0 write suppression and a saturating backpressure counter.
module execute_stage_fifo #(
    parameter int DATA_WIDTH             = 32,
    parameter int REGISTER_ADDRESS_WIDTH = 5,
    parameter int CTRL_WIDTH             = 8,
    parameter int DEPTH                  = 2,
    parameter int STALL_CNT_WIDTH        = 16
) (
    input  logic                              clk,
    input  logic                              rst_ni,
    input  logic                              flush_i,
    input  logic                              valid_i,
    output logic                              ready_o,
    input  logic [CTRL_WIDTH-1:0]             ctrl_i,
    input  logic                              regWrite_i,
    input  logic [REGISTER_ADDRESS_WIDTH-1:0] AD3_i,
    input  logic [DATA_WIDTH-1:0]             ALUresult_i,
    input  logic [DATA_WIDTH-1:0]             RD2_i,
    input  logic [DATA_WIDTH-1:0]             incPC_i,
    output logic                              valid_o,
    input  logic                              ready_i,
    output logic [CTRL_WIDTH-1:0]             ctrl_o,
    output logic                              regWrite_o,
    output logic [REGISTER_ADDRESS_WIDTH-1:0] AD3_o,
    output logic [DATA_WIDTH-1:0]             ALUresult_o,
    output logic [DATA_WIDTH-1:0]             RD2_o,
    output logic [DATA_WIDTH-1:0]             incPC_o,
    output logic [$clog2(DEPTH+1)-1:0]        count_o,
    output logic [STALL_CNT_WIDTH-1:0]        stallCount_o
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    typedef struct packed {
        logic [CTRL_WIDTH-1:0]             ctrl;
        logic                              reg_write;
        logic [REGISTER_ADDRESS_WIDTH-1:0] ad3;
        logic [DATA_WIDTH-1:0]             alu_result;
        logic [DATA_WIDTH-1:0]             rd2;
        logic [DATA_WIDTH-1:0]             inc_pc;
    } entry_t;

    entry_t                     mem [DEPTH];
    entry_t                     wr_entry;
    entry_t                     head;
    logic [PTR_W-1:0]           wr_ptr;
    logic [PTR_W-1:0]           rd_ptr;
    logic [CNT_W-1:0]           count;
    logic [STALL_CNT_WIDTH-1:0] stall_cnt;
    logic                       push;
    logic                       pop;

    // Handshake: a transfer happens on a side only when its valid and ready are both
    // high at the falling edge; ready_o depends on registered occupancy alone.
    assign ready_o = (count < CNT_W'(DEPTH));
    assign valid_o = (count != '0);
    assign push    = valid_i && ready_o;
    assign pop     = valid_o && ready_i;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // Writes to x0 are architecturally void, so the enable is dropped at entry.
    always_comb begin
        wr_entry            = '0;
        wr_entry.ctrl       = ctrl_i;
        wr_entry.reg_write  = regWrite_i && (AD3_i != '0);
        wr_entry.ad3        = AD3_i;
        wr_entry.alu_result = ALUresult_i;
        wr_entry.rd2        = RD2_i;
        wr_entry.inc_pc     = incPC_i;
    end

    always_ff @(negedge clk) begin
        if (rst_ni && !flush_i && push) begin
            mem[wr_ptr] <= wr_entry;
        end
    end

    always_ff @(negedge clk) begin
        if (!rst_ni) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= next_ptr(wr_ptr);
            if (pop)  rd_ptr <= next_ptr(rd_ptr);
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(negedge clk) begin
        if (!rst_ni) begin
            stall_cnt <= '0;
        end else if (valid_i && !ready_o && !flush_i && (stall_cnt != '1)) begin
            stall_cnt <= stall_cnt + 1'b1;
        end
    end

    assign head         = valid_o ? mem[rd_ptr] : '0;
    assign ctrl_o       = head.ctrl;
    assign regWrite_o   = head.reg_write;
    assign AD3_o        = head.ad3;
    assign ALUresult_o  = head.alu_result;
    assign RD2_o        = head.rd2;
    assign incPC_o      = head.inc_pc;
    assign count_o      = count;
    assign stallCount_o = stall_cnt;

endmodule
